// File: rtl/cpu_pkg.sv
// Shared constants for the decode-side register scoreboard.
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned CNT_W_DEF  = 2;
  localparam int unsigned NREG       = 1 << ADDR_W_DEF;
  localparam int unsigned PC_ADDR    = NREG - 1;

  // Issue-control FSM encoding
  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_WAIT_BR = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// One pending-writeback counter: counts issued writes minus retired writebacks.
module sb_counter
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic wb_hit,
  output logic busy_c,
  output logic full_c,
  output logic underflow_c
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] cnt;
  logic                 dec;

  assign busy_c      = (cnt != '0);
  assign full_c      = (cnt == CNT_MAX);
  assign dec         = wb_hit && busy_c;
  // A writeback with nothing outstanding is an upstream protocol error
  assign underflow_c = wb_hit && !busy_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && !dec && !full_c) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end else if (dec && !inc) begin
      cnt <= cnt - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Issue/hazard controller between decode and the register file: RAW/WAW stalls
// plus branch wait and fixed-length flush sequencing.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_W_DEF,
  parameter int unsigned CNT_WIDTH    = CNT_W_DEF,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         id_valid,
  output logic                         id_ready,
  input  logic [ADDR_WIDTH-1:0]        id_rs1,
  input  logic [ADDR_WIDTH-1:0]        id_rs2,
  input  logic                         id_rs1_used,
  input  logic                         id_rs2_used,
  input  logic [ADDR_WIDTH-1:0]        id_rd,
  input  logic                         id_rd_we,
  input  logic                         id_is_branch,
  input  logic                         br_resolve,
  input  logic                         wb_valid,
  input  logic [ADDR_WIDTH-1:0]        wb_addr,
  output logic                         issue,
  output logic                         flush,
  output logic [(1<<ADDR_WIDTH)-1:0]   busy_mask,
  output logic [15:0]                  stall_cnt,
  output logic                         wb_err
);

  localparam int unsigned             NR    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0]   PC    = ADDR_WIDTH'(NR - 1);
  localparam int unsigned             FCW   = 4;

  logic [NR-1:0]  full;
  logic [NR-1:0]  under;
  logic [NR-1:0]  inc_vec;
  logic [NR-1:0]  hit_vec;
  logic           raw;
  logic           waw;
  logic [1:0]     state;
  logic [1:0]     state_nx;
  logic [FCW-1:0] fcnt;
  logic [FCW-1:0] fcnt_nx;

  for (genvar i = 0; i < NR; i++) begin : g_cnt
    assign inc_vec[i] = issue && id_rd_we && (id_rd == ADDR_WIDTH'(i));
    assign hit_vec[i] = wb_valid && (wb_addr == ADDR_WIDTH'(i));

    sb_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .inc         (inc_vec[i]),
      .wb_hit      (hit_vec[i]),
      .busy_c      (busy_mask[i]),
      .full_c      (full[i]),
      .underflow_c (under[i])
    );
  end

  // PC reads are always current, so r15 never causes a RAW stall
  assign raw = (id_rs1_used && (id_rs1 != PC) && busy_mask[id_rs1]) ||
               (id_rs2_used && (id_rs2 != PC) && busy_mask[id_rs2]);
  assign waw = id_rd_we && full[id_rd];

  assign id_ready = (state == ST_RUN) && !raw && !waw;
  assign issue    = id_valid && id_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    case (state)
      ST_RUN: begin
        if (issue && (id_is_branch || (id_rd_we && (id_rd == PC)))) begin
          state_nx = ST_WAIT_BR;
        end
      end
      ST_WAIT_BR: begin
        if (br_resolve) begin
          state_nx = ST_FLUSH;
          fcnt_nx  = FCW'(FLUSH_CYCLES);
        end
      end
      ST_FLUSH: begin
        fcnt_nx = fcnt - FCW'(1);
        if (fcnt == FCW'(1)) begin
          state_nx = ST_RUN;
        end
      end
      default: begin
        state_nx = ST_RUN;
        fcnt_nx  = '0;
      end
    endcase
  end

  // Registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush     <= 1'b0;
      stall_cnt <= '0;
      wb_err    <= 1'b0;
    end else begin
      flush <= (state_nx == ST_FLUSH);
      if (id_valid && !id_ready && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (|under) begin
        wb_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized + directed bench for reg_scoreboard against a behavioural model.
module tb_reg_scoreboard;

  localparam int MAXP = 3;
  localparam int FC   = 2;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [3:0]  id_rs1;
  logic [3:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [3:0]  id_rd;
  logic        id_rd_we;
  logic        id_is_branch;
  logic        br_resolve;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic        issue;
  logic        flush;
  logic [15:0] busy_mask;
  logic [15:0] stall_cnt;
  logic        wb_err;

  reg_scoreboard #(.ADDR_WIDTH(4), .CNT_WIDTH(2), .FLUSH_CYCLES(FC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_rd_we     (id_rd_we),
    .id_is_branch (id_is_branch),
    .br_resolve   (br_resolve),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .issue        (issue),
    .flush        (flush),
    .busy_mask    (busy_mask),
    .stall_cnt    (stall_cnt),
    .wb_err       (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: outstanding writes per register, control mode, counters
  int pend [16];
  int mode;        // 0 running, 1 waiting for branch, 2 flushing
  int fleft;
  int stall;
  bit err;
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) pend[i] = 0;
    mode  = 0;
    fleft = 0;
    stall = 0;
    err   = 1'b0;
  endtask

  task automatic idle();
    id_valid     = 1'b0;
    id_rs1       = 4'd0;
    id_rs2       = 4'd0;
    id_rs1_used  = 1'b0;
    id_rs2_used  = 1'b0;
    id_rd        = 4'd0;
    id_rd_we     = 1'b0;
    id_is_branch = 1'b0;
    br_resolve   = 1'b0;
    wb_valid     = 1'b0;
    wb_addr      = 4'd0;
  endtask

  // Compare current cycle against the model, then advance both one clock
  task automatic tick();
    bit raw, waw, rdy, iss, dec;
    logic [15:0] bm;
    #3;
    raw = (id_rs1_used && id_rs1 != 4'd15 && pend[id_rs1] != 0) ||
          (id_rs2_used && id_rs2 != 4'd15 && pend[id_rs2] != 0);
    waw = id_rd_we && pend[id_rd] == MAXP;
    rdy = (mode == 0) && !raw && !waw;
    iss = id_valid && rdy;
    for (int i = 0; i < 16; i++) bm[i] = (pend[i] != 0);
    chk("id_ready",  32'(id_ready),  32'(rdy));
    chk("issue",     32'(issue),     32'(iss));
    chk("busy_mask", 32'(busy_mask), 32'(bm));
    chk("flush",     32'(flush),     32'(mode == 2));
    chk("stall_cnt", 32'(stall_cnt), 32'(stall));
    chk("wb_err",    32'(wb_err),    32'(err));
    if (!rst_n) begin
      model_reset();
    end else begin
      if (id_valid && !rdy && stall < 65535) stall++;
      dec = wb_valid && pend[wb_addr] != 0;
      if (wb_valid && pend[wb_addr] == 0) err = 1'b1;
      if (iss && id_rd_we) pend[id_rd]++;
      if (dec) pend[wb_addr]--;
      case (mode)
        0: if (iss && (id_is_branch || (id_rd_we && id_rd == 4'd15))) mode = 1;
        1: if (br_resolve) begin mode = 2; fleft = FC; end
        default: begin
          fleft--;
          if (fleft == 0) mode = 0;
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] pick();
    int r;
    r = $urandom % 9;
    return (r == 8) ? 4'd15 : 4'(r);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;

    // Reset/idle
    tick();
    tick();

    // RAW: producer r3, dependent stalls until wb r3 on its third stalled cycle
    id_valid = 1'b1; id_rd_we = 1'b1; id_rd = 4'd3;
    tick();
    id_rd_we = 1'b0; id_rs1 = 4'd3; id_rs1_used = 1'b1;
    tick();
    tick();
    wb_valid = 1'b1; wb_addr = 4'd3;
    tick();
    wb_valid = 1'b0;
    chk("raw_ready_after_wb", 32'(id_ready), 32'd1);
    tick();
    chk("raw_stall_total", 32'(stall_cnt), 32'd3);
    idle();

    // WAW overflow on r5
    id_valid = 1'b1; id_rd_we = 1'b1; id_rd = 4'd5;
    repeat (4) tick();
    wb_valid = 1'b1; wb_addr = 4'd5;
    tick();
    wb_valid = 1'b0;
    tick();
    chk("waw_busy5", 32'(busy_mask[5]), 32'd1);
    idle();
    wb_valid = 1'b1; wb_addr = 4'd5;
    repeat (3) tick();
    idle();

    // Simultaneous issue and writeback on r2
    id_valid = 1'b1; id_rd_we = 1'b1; id_rd = 4'd2;
    tick();
    wb_valid = 1'b1; wb_addr = 4'd2;
    tick();
    idle();
    wb_valid = 1'b1; wb_addr = 4'd2;
    tick();
    idle();
    tick();
    chk("simul_r2_clear", 32'(busy_mask[2]), 32'd0);

    // Two back-to-back branch sequences with decode continuously presenting
    for (int b = 0; b < 2; b++) begin
      idle();
      id_valid = 1'b1; id_is_branch = 1'b1;
      tick();
      id_is_branch = 1'b0;
      tick();
      tick();
      br_resolve = 1'b1;
      tick();
      br_resolve = 1'b0;
      repeat (4) tick();
    end

    // Writeback error, then reset mid-flush
    idle();
    wb_valid = 1'b1; wb_addr = 4'd7;
    tick();
    idle();
    tick();
    chk("wb_err_sticky", 32'(wb_err), 32'd1);
    id_valid = 1'b1; id_rd_we = 1'b1; id_rd = 4'd15;
    tick();
    idle();
    br_resolve = 1'b1;
    tick();
    br_resolve = 1'b0;
    chk("in_flush", 32'(flush), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_err", 32'(wb_err), 32'd0);
    tick();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      logic [3:0] a;
      rst_n        = ($urandom % 400) != 0;
      id_valid     = ($urandom % 5) != 0;
      id_rs1       = pick();
      id_rs2       = pick();
      id_rs1_used  = $urandom % 2;
      id_rs2_used  = $urandom % 2;
      id_rd        = pick();
      id_rd_we     = ($urandom % 3) != 0;
      id_is_branch = ($urandom % 12) == 0;
      br_resolve   = ($urandom % 4) == 0;
      a            = pick();
      wb_addr      = a;
      wb_valid     = (pend[a] != 0) ? 1'($urandom % 2) : (($urandom % 60) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Issue/hazard controller sitting between the decode stage and the register file (16 x 32-bit, registered read ports, r15 = PC auto-advancing).
- Tracks outstanding writebacks per architectural register and stalls decode on RAW and WAW-overflow hazards.
- Sequences control-flow: when a branch or r15 write issues, it blocks issue until the branch resolves, then asserts flush for a fixed number of cycles.

Parameters:
- ADDR_WIDTH, 4, register address width; NREG = 1<<ADDR_WIDTH registers.
- CNT_WIDTH, 2, width of per-register pending-write counter; max outstanding = (1<<CNT_WIDTH)-1.
- FLUSH_CYCLES, 2, cycles flush is held high after branch resolution; legal range 1..15.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  decode presents an instruction.
- id_ready  out  1  scoreboard accepts the instruction this cycle.
- id_rs1, id_rs2  in  ADDR_WIDTH  source register addresses.
- id_rs1_used, id_rs2_used  in  1  source actually read.
- id_rd  in  ADDR_WIDTH  destination address.
- id_rd_we  in  1  instruction writes id_rd.
- id_is_branch  in  1  instruction is a branch.
- br_resolve  in  1  execute reports branch resolved (single-cycle pulse).
- wb_valid  in  1  writeback retiring a register write.
- wb_addr  in  ADDR_WIDTH  register being written back.
- issue  out  1  id_valid && id_ready.
- flush  out  1  squash younger instructions in fetch/decode.
- busy_mask  out  NREG  bit i = pending[i] != 0.
- stall_cnt  out  16  saturating count of cycles with id_valid && !id_ready.
- wb_err  out  1  sticky: writeback seen for a register with pending == 0.

Behaviour:
- Reset (rst_n=0 at edge) sets all pending counters to 0, FSM to RUN, flush=0, stall_cnt=0, wb_err=0. It overrides everything, including a mid-branch or mid-flush state.
- Hazards are combinational from current state and id_* inputs:
  - raw = (rs1_used && rs1!=NREG-1 && pending[rs1]!=0) || the same for rs2.
  - r15 reads never hazard.
  - waw = id_rd_we && pending[id_rd] == max.
- No same-cycle writeback bypass: the register file reads the old value on a write edge, so pending==1 with a simultaneous wb still stalls.
- id_ready = (state==RUN) && !raw && !waw. id_ready does not depend on id_valid.
- Counter update per register r, each edge:
  - inc = issue && id_rd_we && id_rd==r.
  - dec = wb_valid && wb_addr==r && pending[r]!=0.
  - inc and dec together leaves the counter unchanged.
  - wb_valid with pending[r]==0: counter stays 0 and wb_err is set to 1 (sticky until reset).
- FSM:
  - RUN: issue && (id_is_branch || (id_rd_we && id_rd==NREG-1)) -> WAIT_BR.
  - WAIT_BR: id_ready=0. br_resolve -> FLUSH and load flush counter with FLUSH_CYCLES.
  - FLUSH: flush=1 and id_ready=0; counter decrements each cycle; transition to RUN on the edge where it reaches 0. flush is high for exactly FLUSH_CYCLES cycles.
  - br_resolve outside WAIT_BR is ignored.
- flush is a registered output, first asserted the cycle after the br_resolve edge.
- Writebacks continue to be processed in every FSM state.
- The r15 pending counter is still maintained for r15 writes; it only affects WAW stalls.
- stall_cnt increments when id_valid && !id_ready, for any cause including WAIT_BR/FLUSH, and saturates at 0xFFFF.
- busy_mask is combinational from the counters.
- Latency: an instruction is accepted in the same cycle id_ready is high. A dependent instruction can issue in the cycle after its producer's wb_valid edge.

Decomposition:
- Shared package (cpu_pkg): NREG, PC_ADDR (NREG-1), FSM state enum {RUN, WAIT_BR, FLUSH}, CNT_WIDTH default.
- One sub-module, sb_counter: a single up/down pending counter with saturation flag and underflow-error output, instantiated NREG times via generate.

Test Plan:
- Reset then idle: busy_mask=0, id_ready=1, flush=0, stall_cnt=0.
- RAW: issue rd=r3; next cycle present rs1=r3 used -> id_ready=0. wb_valid r3 at cycle 4 -> id_ready=1 at cycle 5. stall_cnt=3.
- WAW overflow: issue rd=r5 three times with no writeback -> fourth write to r5 stalls. One wb r5 -> accepted next cycle, busy_mask[5]=1.
- Simultaneous issue rd=r2 and wb r2 with pending[2]=1 -> pending stays 1.
- Branch: issue branch, then br_resolve 3 cycles later -> flush high exactly 2 cycles, id_ready=0 throughout, RUN afterwards. A second branch follows the same sequence.
- Error and reset: wb r7 with pending=0 -> wb_err=1 sticks. rst_n=0 during FLUSH -> next cycle state RUN, flush=0, wb_err=0, counters 0.
